// File: rtl/code_sequencer.sv
// code_sequencer
//   Pulse-repetition sequencer for the transmitter. A free-running period
//   counter fires a trigger every prf_period clocks; on each trigger the
//   programmable code word is latched and played out LSB-first, one chip
//   every chip_cycles clocks, with sinc framing the pulse. All outputs are
//   registered.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   en           sequencer enable (low forces the period counter to 0 and
//                aborts any pulse in flight)
//   code_word    code bits, chip k = code_word[k]
//   code_len     number of chips (0 -> 1, above MAX_CHIPS -> MAX_CHIPS)
//   chip_cycles  clocks per chip (0 -> 1)
//   prf_period   clocks between pulse starts (below 2 disables pulsing)
//   code         current chip value, 0 whenever sinc is 0
//   sinc         high for exactly code_len*chip_cycles cycles per pulse
//   pulse_start  one-cycle strobe on the first cycle of sinc
//   chip_idx     index of the chip currently on code
//   busy         copy of sinc
//   overrun      sticky: a trigger arrived while a pulse was still running
module code_sequencer #(
  parameter int MAX_CHIPS = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [MAX_CHIPS-1:0] code_word,
  input  logic [5:0]           code_len,
  input  logic [CNT_W-1:0]     chip_cycles,
  input  logic [CNT_W-1:0]     prf_period,
  output logic                 code,
  output logic                 sinc,
  output logic                 pulse_start,
  output logic [4:0]           chip_idx,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
  localparam logic [5:0]       LEN_MAX = 6'(MAX_CHIPS);

  typedef enum logic {IDLE, TX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     pcnt_q, pcnt_d;
  logic [CNT_W-1:0]     ccnt_q, ccnt_d;
  logic [4:0]           chip_idx_q, chip_idx_d;
  logic                 code_q, code_d;
  logic                 sinc_q, sinc_d;
  logic                 ps_q, ps_d;
  logic                 ovr_q, ovr_d;

  // Shadow copy of the configuration, frozen for the whole pulse.
  logic [MAX_CHIPS-1:0] word_s_q;
  logic [5:0]           len_s_q;
  logic [CNT_W-1:0]     cc_s_q;
  logic                 load;

  logic                 run, trigger, chip_wrap, last_chip;
  logic [4:0]           idx_inc;

  function automatic logic [5:0] sat_len(input logic [5:0] l);
    if (l == 6'd0)         return 6'd1;
    else if (l > LEN_MAX)  return LEN_MAX;
    else                   return l;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cc(input logic [CNT_W-1:0] c);
    return (c == '0) ? CNT_ONE : c;
  endfunction

  // Period timer and trigger
  always_comb begin
    run     = en && (prf_period >= CNT_TWO);
    trigger = run && (pcnt_q == '0);
    pcnt_d  = '0;
    // The >= also recovers if prf_period is lowered below the current count.
    if (run) pcnt_d = (pcnt_q >= prf_period - CNT_ONE) ? '0 : pcnt_q + CNT_ONE;
  end

  assign chip_wrap = (ccnt_q == cc_s_q - CNT_ONE);
  assign last_chip = !({1'b0, chip_idx_q} < len_s_q - 6'd1);
  assign idx_inc   = chip_idx_q + 5'd1;

  // Sequencer FSM next state
  always_comb begin
    state_d    = state_q;
    ccnt_d     = ccnt_q;
    chip_idx_d = chip_idx_q;
    code_d     = code_q;
    sinc_d     = sinc_q;
    ps_d       = 1'b0;
    ovr_d      = ovr_q;
    load       = 1'b0;

    unique case (state_q)
      IDLE: begin
        ccnt_d     = '0;
        chip_idx_d = '0;
        code_d     = 1'b0;
        sinc_d     = 1'b0;
        if (trigger) load = 1'b1;
      end
      TX: begin
        if (!en) begin
          state_d    = IDLE;
          ccnt_d     = '0;
          chip_idx_d = '0;
          code_d     = 1'b0;
          sinc_d     = 1'b0;
        end else if (chip_wrap && last_chip) begin
          // Final cycle of the pulse counts as idle, so a coincident
          // trigger starts the next pulse seamlessly without overrun.
          if (trigger) begin
            load = 1'b1;
          end else begin
            state_d    = IDLE;
            ccnt_d     = '0;
            chip_idx_d = '0;
            code_d     = 1'b0;
            sinc_d     = 1'b0;
          end
        end else begin
          if (trigger) ovr_d = 1'b1;
          if (chip_wrap) begin
            ccnt_d     = '0;
            chip_idx_d = idx_inc;
            code_d     = word_s_q[idx_inc];
          end else begin
            ccnt_d = ccnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d    = TX;
      ccnt_d     = '0;
      chip_idx_d = '0;
      code_d     = code_word[0];
      sinc_d     = 1'b1;
      ps_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      ccnt_q     <= '0;
      chip_idx_q <= '0;
      code_q     <= 1'b0;
      sinc_q     <= 1'b0;
      ps_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      ccnt_q     <= ccnt_d;
      chip_idx_q <= chip_idx_d;
      code_q     <= code_d;
      sinc_q     <= sinc_d;
      ps_q       <= ps_d;
      ovr_q      <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      word_s_q <= code_word;
      len_s_q  <= sat_len(code_len);
      cc_s_q   <= sat_cc(chip_cycles);
    end
  end

  assign code        = code_q;
  assign sinc        = sinc_q;
  assign busy        = sinc_q;
  assign pulse_start = ps_q;
  assign chip_idx    = chip_idx_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_code_sequencer.sv
module tb_code_sequencer;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] code_word;
  logic [5:0]  code_len;
  logic [15:0] chip_cycles, prf_period;
  logic        code, sinc, pulse_start, busy, overrun;
  logic [4:0]  chip_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  code_sequencer #(.MAX_CHIPS(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .code_word(code_word), .code_len(code_len),
    .chip_cycles(chip_cycles), .prf_period(prf_period), .code(code), .sinc(sinc),
    .pulse_start(pulse_start), .chip_idx(chip_idx), .busy(busy), .overrun(overrun)
  );

  // Reference model: a pulse is "active" for len*cc cycles counted from its
  // start; the chip on air is elapsed/cc.
  int          m_pc, m_len, m_cc, m_elapsed;
  logic [31:0] m_word;
  bit          m_active, m_ovr, m_ps;
  int          e_idx;
  logic        e_code;

  task automatic model_edge();
    bit run, trig, ending;
    if (!rst) begin
      m_pc = 0; m_active = 0; m_elapsed = 0; m_ovr = 0; m_ps = 0;
    end else begin
      run    = en && (prf_period >= 2);
      trig   = run && (m_pc == 0);
      ending = m_active && (m_elapsed + 1 >= m_len * m_cc);
      m_ps   = 0;
      if (!en) m_active = 0;
      else if (m_active && !ending) begin
        if (trig) m_ovr = 1;
        m_elapsed++;
      end else if (trig) begin
        m_word    = code_word;
        m_len     = (code_len == 0) ? 1 : (code_len > 32) ? 32 : int'(code_len);
        m_cc      = (chip_cycles == 0) ? 1 : int'(chip_cycles);
        m_active  = 1;
        m_elapsed = 0;
        m_ps      = 1;
      end else m_active = 0;
      m_pc = run ? ((m_pc + 1 >= int'(prf_period)) ? 0 : m_pc + 1) : 0;
    end
    e_idx  = m_active ? m_elapsed / m_cc : 0;
    e_code = m_active ? m_word[e_idx] : 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sinc", {31'd0, sinc}, {31'd0, m_active});
    chk("busy", {31'd0, busy}, {31'd0, m_active});
    chk("code", {31'd0, code}, {31'd0, e_code});
    chk("chip_idx", {27'd0, chip_idx}, e_idx);
    chk("pulse_start", {31'd0, pulse_start}, {31'd0, m_ps});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Runs n cycles and returns how many had sinc / pulse_start high.
  task automatic count_n(input int n, output int n_sinc, output int n_ps);
    n_sinc = 0; n_ps = 0;
    for (int i = 0; i < n; i++) begin
      step();
      n_sinc += int'(sinc);
      n_ps   += int'(pulse_start);
    end
  endtask

  task automatic cfg(input logic [31:0] w, input logic [5:0] l,
                     input logic [15:0] cc, input logic [15:0] p);
    code_word = w; code_len = l; chip_cycles = cc; prf_period = p;
  endtask

  logic barker [13];
  int   ns, np;

  initial begin
    barker = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    m_word = '0; m_len = 1; m_cc = 1;
    rst = 1'b0; en = 1'b1;
    cfg(32'h1F35, 6'd13, 16'd4, 16'd100);

    // Reset hold with en high
    step_n(5);
    chk("rst_sinc", {31'd0, sinc}, 32'd0);
    chk("rst_ps", {31'd0, pulse_start}, 32'd0);

    // Barker-13: first pulse on the first edge after release
    rst = 1'b1;
    ns = 0; np = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0) chk("first_ps", {31'd0, pulse_start}, 32'd1);
      if (i < 52 && (i % 4) == 0) chk("barker_chip", {31'd0, code}, {31'd0, barker[i / 4]});
      if (i < 52 && (i % 4) == 3) chk("barker_idx", {27'd0, chip_idx}, i / 4);
      ns += int'(sinc);
      np += int'(pulse_start);
    end
    chk("barker_sinc_cnt", ns, 156);
    chk("barker_ps_cnt", np, 3);

    // Overrun: 200-cycle pulses on a 150-cycle period
    en = 1'b0; step();
    cfg(32'h2AB, 6'd10, 16'd20, 16'd150);
    en = 1'b1;
    count_n(450, ns, np);
    chk("ovr_ps_cnt", np, 2);
    chk("ovr_sinc_cnt", ns, 350);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);

    // Exact fit: back-to-back pulses, sinc never drops
    rst = 1'b0; step();
    cfg(32'h15, 6'd5, 16'd10, 16'd50);
    rst = 1'b1;
    count_n(200, ns, np);
    chk("fit_sinc_cnt", ns, 200);
    chk("fit_ps_cnt", np, 4);
    chk("fit_ovr", {31'd0, overrun}, 32'd0);

    // Mid-pulse config change applies only to the next pulse
    rst = 1'b0; step();
    cfg(32'h1F35, 6'd13, 16'd4, 16'd100);
    rst = 1'b1;
    step_n(20);
    code_word = 32'h0000_00AA;
    step_n(80);
    step();
    chk("new_word_ps", {31'd0, pulse_start}, 32'd1);
    chk("new_word_chip0", {31'd0, code}, 32'd0);
    step_n(10);

    // Degenerate values
    en = 1'b0; step();
    cfg(32'h5, 6'd3, 16'd0, 16'd20);
    en = 1'b1;
    count_n(20, ns, np);
    chk("cc0_sinc_cnt", ns, 3);
    en = 1'b0; step();
    cfg(32'h1, 6'd0, 16'd2, 16'd20);
    en = 1'b1;
    count_n(20, ns, np);
    chk("len0_sinc_cnt", ns, 2);
    en = 1'b0; step();
    cfg(32'hDEAD_BEEF, 6'd40, 16'd1, 16'd64);
    en = 1'b1;
    count_n(64, ns, np);
    chk("len_clamp_cnt", ns, 32);
    en = 1'b0; step();
    cfg(32'hF, 6'd4, 16'd1, 16'd1);
    en = 1'b1;
    count_n(30, ns, np);
    chk("prf1_no_pulse", np, 0);

    // Abort during chip 2
    en = 1'b0; step();
    cfg(32'h1F35, 6'd13, 16'd4, 16'd100);
    en = 1'b1;
    for (int i = 0; i < 40 && chip_idx != 5'd2; i++) step();
    chk("abort_reach_chip2", {27'd0, chip_idx}, 32'd2);
    en = 1'b0; step();
    chk("abort_sinc", {31'd0, sinc}, 32'd0);
    chk("abort_code", {31'd0, code}, 32'd0);
    chk("abort_idx", {27'd0, chip_idx}, 32'd0);
    en = 1'b1; step();
    chk("reen_ps", {31'd0, pulse_start}, 32'd1);
    step_n(60);

    // Randomised segments against the model
    for (int s = 0; s < 25; s++) begin
      cfg($urandom, 6'($urandom_range(0, 40)), 16'($urandom_range(0, 6)),
          16'($urandom_range(0, 120)));
      if ($urandom_range(0, 9) == 0) rst = 1'b0;
      en = ($urandom_range(0, 5) != 0);
      step();
      rst = 1'b1;
      for (int i = 0; i < int'($urandom_range(40, 250)); i++) begin
        if ($urandom_range(0, 199) == 0) en = ~en;
        if ($urandom_range(0, 99) == 0) code_word = $urandom;
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
